case_sequencer: RTL and testbench

Multi-channel, parametrised counter-classifier. Each channel holds a WIDTH-bit count that steps up or down on request, wraps or saturates at LIMIT, and is mapped to an output code through a grouped (fallthrough) classification: a low range, a single mid value, and a default. A registered read port returns any channel's count and code with one-cycle latency. It sits beside control logic that needs per-channel phase/status codes derived from free-running counters.

---
 rtl/case_seq_pkg.sv | 32 +++
 rtl/case_seq_chan.sv | 80 ++++++++
 rtl/case_sequencer.sv | 94 +++++++++
 tb/tb_case_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/case_seq_pkg.sv
// Shared types and helpers for the case_sequencer counter-classifier.
// Latency: n/a (types, constants and a pure classification function).
// Backpressure: n/a.
package case_seq_pkg;

    // Classification groups a count can fall into
    typedef enum logic [1:0] {
        CLS_LOW,
        CLS_MID,
        CLS_DEF
    } cls_e;

    // Code type at the default width
    typedef logic [7:0] code_t;

    localparam int DEF_LOW_CODE = 10;
    localparam int DEF_MID_CODE = 20;
    localparam int DEF_DEF_CODE = 30;

    // Fallthrough grouping: low range first, then the single mid value, else default
    function automatic cls_e classify(input int cnt, input int low_max, input int mid_val);
        cls_e cls;
        cls = CLS_DEF;
        if (cnt <= low_max) begin
            cls = CLS_LOW;
        end else if (cnt == mid_val) begin
            cls = CLS_MID;
        end
        return cls;
    endfunction

endpackage

// File: rtl/case_seq_chan.sv
// One up/down counter with wrap-or-saturate at LIMIT, wrap pulse and code output.
// Latency: count and wrap_pulse registered (1 cycle); code is combinational from count.
// Backpressure: none; a step request is always accepted.
module case_seq_chan
    import case_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LIMIT    = 255,
    parameter int LOW_MAX  = 2,
    parameter int MID_VAL  = 3,
    parameter int LOW_CODE = DEF_LOW_CODE,
    parameter int MID_CODE = DEF_MID_CODE,
    parameter int DEF_CODE = DEF_DEF_CODE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             clr,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] code,
    output logic             wrap_pulse
);

    localparam logic [WIDTH:0]   LIM_EXT = (WIDTH + 1)'(LIMIT);
    localparam logic [WIDTH-1:0] LIM_W   = WIDTH'(LIMIT);

    logic [WIDTH:0]   inc_ext;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    // Next count: clear beats tick; increment is one bit wider so LIMIT = 2^WIDTH-1 cannot overflow
    always_comb begin
        inc_ext   = {1'b0, count} + (WIDTH + 1)'(1);
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (tick) begin
            if (!dir) begin
                if (inc_ext <= LIM_EXT) begin
                    count_nxt = inc_ext[WIDTH-1:0];
                end else if (!sat) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_nxt = count - WIDTH'(1);
                end else if (!sat) begin
                    count_nxt = LIM_W;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    // Count and wrap pulse registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

    // Map the registered count to its output code
    always_comb begin
        code = WIDTH'(DEF_CODE);
        unique case (classify(int'(count), LOW_MAX, MID_VAL))
            CLS_LOW: code = WIDTH'(LOW_CODE);
            CLS_MID: code = WIDTH'(MID_CODE);
            default: code = WIDTH'(DEF_CODE);
        endcase
    end

endmodule

// File: rtl/case_sequencer.sv
// Multi-channel counter-classifier with a registered read port and optional wrap irq.
// Latency: counts/codes 1 cycle after tick; read result 1 cycle after rd_req.
// Backpressure: none; unread results are overwritten. CASE_SEQ_WRAP_IRQ_EN enables sticky wrap irq.
module case_sequencer
    import case_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int LIMIT    = 255,
    parameter int LOW_MAX  = 2,
    parameter int MID_VAL  = 3,
    parameter int LOW_CODE = DEF_LOW_CODE,
    parameter int MID_CODE = DEF_MID_CODE,
    parameter int DEF_CODE = DEF_DEF_CODE,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       tick_en,
    input  logic [CHANNELS-1:0]       clear,
    input  logic                      dir,
    input  logic                      sat,
    input  logic                      rd_req,
    input  logic [CW-1:0]             rd_chan,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_count,
    output logic [WIDTH-1:0]          rd_code,
    output logic [CHANNELS*WIDTH-1:0] code_ret,
    output logic [CHANNELS-1:0]       wrap_pulse,
    output logic                      irq
);

    logic [WIDTH-1:0] counts [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        case_seq_chan #(
            .WIDTH    (WIDTH),
            .LIMIT    (LIMIT),
            .LOW_MAX  (LOW_MAX),
            .MID_VAL  (MID_VAL),
            .LOW_CODE (LOW_CODE),
            .MID_CODE (MID_CODE),
            .DEF_CODE (DEF_CODE)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .tick       (tick_en[g]),
            .clr        (clear[g]),
            .dir        (dir),
            .sat        (sat),
            .count      (counts[g]),
            .code       (code_ret[g*WIDTH +: WIDTH]),
            .wrap_pulse (wrap_pulse[g])
        );
    end

    // Read pipeline: capture the pre-edge count/code; nonexistent channels read as zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_count <= '0;
            rd_code  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (int'(rd_chan) < CHANNELS) begin
                    rd_count <= counts[rd_chan];
                    rd_code  <= code_ret[int'(rd_chan)*WIDTH +: WIDTH];
                end else begin
                    rd_count <= '0;
                    rd_code  <= '0;
                end
            end
        end
    end

`ifdef CASE_SEQ_WRAP_IRQ_EN
    logic [CHANNELS-1:0] wrap_flag;

    // Sticky per-channel wrap flags (clear wins) and the registered OR that drives irq
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrap_flag <= '0;
            irq       <= 1'b0;
        end else begin
            wrap_flag <= (wrap_flag | wrap_pulse) & ~clear;
            irq       <= |wrap_flag;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_case_sequencer.sv
// Randomized + directed bench for case_sequencer with a scoreboard.
// Stimulus pushes expected per-cycle state and read results; a monitor pops and compares.
// Five channels are used so rd_chan can address channels that do not exist.
module tb_case_sequencer;

    localparam int W    = 8;
    localparam int CH   = 5;
    localparam int LIM  = 255;
    localparam int LOWM = 2;
    localparam int MIDV = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [CH-1:0]   tick_en = '0;
    logic [CH-1:0]   clear = '0;
    logic            dir = 1'b0;
    logic            sat = 1'b0;
    logic            rd_req = 1'b0;
    logic [2:0]      rd_chan = '0;
    logic            rd_valid;
    logic [W-1:0]    rd_count;
    logic [W-1:0]    rd_code;
    logic [CH*W-1:0] code_ret;
    logic [CH-1:0]   wrap_pulse;
    logic            irq;

    case_sequencer #(
        .WIDTH(W), .CHANNELS(CH), .LIMIT(LIM), .LOW_MAX(LOWM), .MID_VAL(MIDV),
        .LOW_CODE(10), .MID_CODE(20), .DEF_CODE(30)
    ) dut (
        .clock(clock), .reset(reset), .tick_en(tick_en), .clear(clear),
        .dir(dir), .sat(sat), .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_valid(rd_valid), .rd_count(rd_count), .rd_code(rd_code),
        .code_ret(code_ret), .wrap_pulse(wrap_pulse), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CH*W-1:0] code;
        logic [CH-1:0]   wrap;
        logic            irq;
        logic            rdv;
        logic            rd_zero;
    } st_t;

    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] code;
    } rd_t;

    st_t st_q[$];
    rd_t rd_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_cnt [CH];
    logic [CH-1:0] m_wrap = '0;
    logic [CH-1:0] m_flag = '0;
    logic          m_irq = 1'b0;

    function automatic int exp_code(input int c);
        if (c <= LOWM) return 10;
        if (c == MIDV) return 20;
        return 30;
    endfunction

    // Drive one cycle of inputs at the falling edge and record what the next rising edge must produce
    task automatic step(input logic rst_i, input logic [CH-1:0] t, input logic [CH-1:0] c,
                        input logic d, input logic s, input logic r, input logic [2:0] ch);
        st_t e;
        rd_t rr;
        logic [CH-1:0] wrap_n;
        @(negedge clock);
        reset   = rst_i;
        tick_en = t;
        clear   = c;
        dir     = d;
        sat     = s;
        rd_req  = r;
        rd_chan = ch;
        wrap_n  = '0;
        if (rst_i) begin
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
            m_wrap = '0;
            m_flag = '0;
            m_irq  = 1'b0;
            e.rdv     = 1'b0;
            e.rd_zero = 1'b1;
        end else begin
            if (r) begin
                if (int'(ch) < CH) begin
                    rr.cnt  = W'(m_cnt[ch]);
                    rr.code = W'(exp_code(m_cnt[ch]));
                end else begin
                    rr.cnt  = '0;
                    rr.code = '0;
                end
                rd_q.push_back(rr);
            end
            for (int i = 0; i < CH; i++) begin
                if (c[i]) begin
                    m_cnt[i] = 0;
                end else if (t[i]) begin
                    if (!d) begin
                        if (m_cnt[i] < LIM) m_cnt[i] = m_cnt[i] + 1;
                        else if (!s) begin m_cnt[i] = 0; wrap_n[i] = 1'b1; end
                    end else begin
                        if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                        else if (!s) begin m_cnt[i] = LIM; wrap_n[i] = 1'b1; end
                    end
                end
            end
`ifdef CASE_SEQ_WRAP_IRQ_EN
            m_irq  = |m_flag;
            m_flag = (m_flag | m_wrap) & ~c;
`else
            m_irq  = 1'b0;
`endif
            m_wrap    = wrap_n;
            e.rdv     = r;
            e.rd_zero = 1'b0;
        end
        for (int i = 0; i < CH; i++) e.code[i*W +: W] = W'(exp_code(m_cnt[i]));
        e.wrap = m_wrap;
        e.irq  = m_irq;
        st_q.push_back(e);
    endtask

    task automatic tick(input logic [CH-1:0] t, input logic d, input logic s);
        step(1'b0, t, '0, d, s, 1'b0, 3'd0);
    endtask

    task automatic read(input logic [2:0] ch);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ch);
    endtask

    // Monitor: just after each rising edge, compare outputs with the oldest expectation
    st_t me;
    rd_t mr;
    always @(posedge clock) begin
        #1;
        if (st_q.size() > 0) begin
            me = st_q.pop_front();
            checks++;
            if (code_ret !== me.code) begin
                errors++;
                $display("FAIL code_ret got=%h exp=%h t=%0t", code_ret, me.code, $time);
            end
            checks++;
            if (wrap_pulse !== me.wrap) begin
                errors++;
                $display("FAIL wrap_pulse got=%b exp=%b t=%0t", wrap_pulse, me.wrap, $time);
            end
            checks++;
            if (irq !== me.irq) begin
                errors++;
                $display("FAIL irq got=%b exp=%b t=%0t", irq, me.irq, $time);
            end
            checks++;
            if (rd_valid !== me.rdv) begin
                errors++;
                $display("FAIL rd_valid got=%b exp=%b t=%0t", rd_valid, me.rdv, $time);
            end
            if (me.rd_zero) begin
                checks++;
                if (rd_count !== '0 || rd_code !== '0) begin
                    errors++;
                    $display("FAIL rd_reset got=%0d/%0d exp=0/0 t=%0t", rd_count, rd_code, $time);
                end
            end
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got rd_valid=1 exp no pending read t=%0t", $time);
            end else begin
                mr = rd_q.pop_front();
                if (rd_count !== mr.cnt || rd_code !== mr.code) begin
                    errors++;
                    $display("FAIL rd_data got=%0d/%0d exp=%0d/%0d t=%0t",
                             rd_count, rd_code, mr.cnt, mr.code, $time);
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] rt;
        logic [CH-1:0] rc;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;

        // Reset state
        step(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 3'd0);

        // ch0 counts up 0..4: codes 10,10,10,20,30
        for (int k = 0; k < 4; k++) tick(5'b00001, 1'b0, 1'b0);

        // ch1 to LIMIT, wrap up, wrap back down, then saturate at LIMIT
        for (int k = 0; k < 255; k++) tick(5'b00010, 1'b0, 1'b0);
        read(3'd1);
        tick(5'b00010, 1'b0, 1'b0);
        tick(5'b00010, 1'b1, 1'b0);
        tick(5'b00010, 1'b0, 1'b1);
        read(3'd1);

        // ch2 down from 0 wraps to LIMIT; saturating down at 0 on ch4 holds
        tick(5'b00100, 1'b1, 1'b0);
        tick(5'b10000, 1'b1, 1'b1);
        read(3'd2);
        read(3'd4);
        step(1'b0, '0, 5'b00100, 1'b0, 1'b0, 1'b0, 3'd0);

        // ch3 to 7, then clear and tick together
        for (int k = 0; k < 7; k++) tick(5'b01000, 1'b0, 1'b0);
        step(1'b0, 5'b01000, 5'b01000, 1'b0, 1'b0, 1'b1, 3'd3);
        read(3'd3);

        // ch0 from 3: read and tick on the same edge returns the pre-tick value
        step(1'b0, '0, 5'b00001, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) tick(5'b00001, 1'b0, 1'b0);
        step(1'b0, 5'b00001, '0, 1'b0, 1'b0, 1'b1, 3'd0);
        read(3'd5);
        read(3'd6);
        read(3'd7);
        read(3'd0);

        // Reset asserted alongside a read request drops the read
        step(1'b1, 5'b11111, '0, 1'b0, 1'b0, 1'b1, 3'd1);
        read(3'd1);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            rt = CH'($urandom);
            rc = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            step(($urandom_range(0, 199) == 0), rt, rc, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)));
        end
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 3'd0);

        @(posedge clock);
        #3;
        checks++;
        if (st_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d pending exp=0/0", st_q.size(), rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
